// File: rtl/risc_fetch_unit.sv
// risc_fetch_unit: instruction fetch stage for the RISC core.
// Drives the instruction-memory address, captures the returned word into the
// instruction register and hands it to decode with its fetch address and a
// valid flag. Supports stall, branch redirect with a one-bubble flush,
// halt (exit only by branch or reset) and a one-cycle PC wrap pulse.
//
// Ports:
//   clk           in   clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   instruction   in   [IW] memory read data for address pc (same cycle)
//   stall         in   decode cannot accept; hold fetch state
//   branch_taken  in   redirect fetch to branch_target
//   branch_target in   [AW] redirect address
//   halt          in   stop fetching, enter HALTED
//   pc            out  [AW] current fetch address
//   ir            out  [IW] instruction register to decode
//   ir_pc         out  [AW] address the word in ir came from
//   ir_valid      out  ir holds a real fetched instruction
//   halted        out  unit is in HALTED
//   pc_wrap       out  one-cycle pulse after pc advanced from all-ones to 0
module risc_fetch_unit #(
  parameter int unsigned     IW       = 13,
  parameter int unsigned     AW       = 5,
  parameter logic [IW-1:0]   NOP      = '0,
  parameter logic [AW-1:0]   RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [IW-1:0] instruction,
  input  logic          stall,
  input  logic          branch_taken,
  input  logic [AW-1:0] branch_target,
  input  logic          halt,
  output logic [AW-1:0] pc,
  output logic [IW-1:0] ir,
  output logic [AW-1:0] ir_pc,
  output logic          ir_valid,
  output logic          halted,
  output logic          pc_wrap
);

  typedef enum logic {RUN, HALTED} state_t;

  state_t state, state_next;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_next;
  end

  // Next-state logic: branch always returns to RUN, halt only acts from RUN
  always_comb begin
    state_next = state;
    if (branch_taken)              state_next = RUN;
    else if (state == RUN && halt) state_next = HALTED;
  end

  // Output decode
  always_comb begin
    halted = (state == HALTED);
  end

  // Fetch datapath, priority: branch > halted/halt > stall > advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      ir       <= NOP;
      ir_pc    <= '0;
      ir_valid <= 1'b0;
      pc_wrap  <= 1'b0;
    end else begin
      pc_wrap <= 1'b0;
      if (branch_taken) begin
        // Flush: the word currently at pc is discarded, ir_pc keeps its value
        pc       <= branch_target;
        ir       <= NOP;
        ir_valid <= 1'b0;
      end else if (state == HALTED) begin
        ir_valid <= 1'b0;
      end else if (halt) begin
        ir       <= NOP;
        ir_valid <= 1'b0;
      end else if (!stall) begin
        ir       <= instruction;
        ir_pc    <= pc;
        ir_valid <= 1'b1;
        pc       <= pc + AW'(1);
        pc_wrap  <= (pc == '1);
      end
    end
  end

endmodule

// File: doc/risc_fetch_unit.md
Name: risc_fetch_unit

Overview:
Parametrised instruction fetch unit for the RISC core. It generates the instruction-memory address, captures the returned instruction into the instruction register, and passes it to decode with a valid flag and the fetch address. It adds stall, branch redirect with one-bubble flush, halt/resume control, and a PC wrap indication. It sits between instruction memory and the decode stage.

Parameters:
IW, 13, instruction width in bits
AW, 5, PC/address width in bits; address space is 2^AW words
NOP, {IW{1'b0}}, instruction value inserted on reset, flush and halt
RESET_PC, 0, PC value after reset (AW bits)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
instruction  input  IW  memory read data for address pc; combinational, valid in the same cycle
stall  input  1  decode cannot accept; hold all fetch state
branch_taken  input  1  redirect fetch to branch_target
branch_target  input  AW  redirect address
halt  input  1  stop fetching; enter HALTED
pc  output  AW  current fetch address to instruction memory
ir  output  IW  instruction register to decode
ir_pc  output  AW  address the instruction in ir was fetched from
ir_valid  output  1  ir holds a real fetched instruction
halted  output  1  fetch unit is in HALTED state
pc_wrap  output  1  one-cycle pulse: pc advanced from 2^AW-1 to 0

Behaviour:
- Reset (rst_n=0, asynchronous): pc=RESET_PC, ir=NOP, ir_pc=0, ir_valid=0, halted=0, pc_wrap=0, state=RUN.
- States: RUN, HALTED. halted = (state==HALTED).
- Latency: instruction at pc in cycle n appears on ir, with ir_pc=pc(n) and ir_valid=1, after edge n+1.
- Per-edge priority, highest first: branch_taken > halt > stall > normal advance.
- RUN, normal advance: ir<=instruction; ir_pc<=pc; ir_valid<=1; pc<=pc+1 modulo 2^AW.
- Wrap: when pc==2^AW-1 advances, pc becomes 0 and pc_wrap=1 for exactly the following cycle. pc_wrap=0 on every other edge, including when a branch targets 0.
- RUN, stall=1: pc, ir, ir_pc and ir_valid hold. pc_wrap=0.
- branch_taken=1, in any state: pc<=branch_target; ir<=NOP; ir_valid<=0; ir_pc holds; state<=RUN.
  - This is a one-bubble flush: the instruction currently at pc is discarded.
  - stall and halt are ignored on that edge.
- RUN, halt=1 (no branch): state<=HALTED; ir<=NOP; ir_valid<=0; pc holds; stall is ignored.
- HALTED: pc, ir and ir_pc hold; ir_valid=0; stall and halt are ignored.
  - Exit only by branch_taken (resume at branch_target) or by reset.
- Simultaneous branch_taken and halt: branch wins; the unit stays in or returns to RUN.
- Reset asserted mid-operation: all outputs take their reset values immediately, regardless of clk.
  - On the first rising edge after rst_n deasserts, the instruction at RESET_PC is fetched normally.
- Arithmetic: PC increment is AW bits wide and discards the carry. branch_target is used unmodified.

Test Plan:
- Reset then free-run, IW=13, AW=5, memory word k = k+0x100 -> after edge 1: ir=0x100, ir_pc=0, ir_valid=1, pc=1. Steady one instruction per cycle.
- Run to pc=31 -> next edge: pc=0, ir_pc=31, pc_wrap=1 for one cycle only. Run to pc=0 by branch -> pc_wrap stays 0.
- stall high 3 cycles at pc=7 -> pc=7, ir and ir_pc unchanged, ir_valid unchanged for 3 cycles. Release -> ir_pc=7 next edge.
- branch_taken with branch_target=20 while stall=1 at pc=9 -> pc=20, ir=NOP, ir_valid=0. Next edge: ir=mem[20], ir_pc=20, ir_valid=1.
- halt at pc=4 -> halted=1, ir_valid=0, pc stays 4 for 10 cycles despite stall/halt toggling. branch_taken target 2 -> halted=0, pc=2. Next edge: ir_pc=2.
- Assert rst_n low asynchronously mid-cycle at pc=15 with ir_valid=1 -> pc=0, ir=NOP, ir_valid=0, halted=0 before the next clk edge.
